// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and helpers for the two-master on-chip SRAM arbiter.
package onchip_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  typedef logic [0:0] master_idx_t;

  localparam int NUM_MASTERS = 2;

  // Counter must hold READ_LATENCY itself, so size it for READ_LATENCY+1 values.
  function automatic int lat_cnt_w(input int read_latency);
    return $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master
// that was not granted last.
module rr_pick2
  import onchip_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? ~rr_last : req[1];
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port SRAM between two Avalon-MM masters, round-robin,
// with at most one transaction in flight.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int CNT_W = lat_cnt_w(READ_LATENCY);

  state_t                   r_state;
  state_t                   w_state_next;
  master_idx_t              r_grant;
  master_idx_t              r_rr_last;
  logic                     w_winner;
  logic                     w_pick_valid;
  logic                     w_load;
  logic                     w_issue;
  logic                     w_rd_done;

  logic [NUM_MASTERS-1:0]   w_read;
  logic [NUM_MASTERS-1:0]   w_write;
  logic [NUM_MASTERS-1:0]   w_req;
  logic [NUM_MASTERS-1:0]   w_wait;
  logic [ADDR_W-1:0]        w_addr  [NUM_MASTERS];
  logic [BE_W-1:0]          w_be    [NUM_MASTERS];
  logic [DATA_W-1:0]        w_wdata [NUM_MASTERS];

  logic                     r_is_write;
  logic [ADDR_W-1:0]        r_addr;
  logic [BE_W-1:0]          r_be;
  logic [DATA_W-1:0]        r_wdata;
  logic [CNT_W-1:0]         r_cnt;
  logic [DATA_W-1:0]        r_rdata [NUM_MASTERS];
  logic [NUM_MASTERS-1:0]   r_rdv;

  assign w_read     = {m1_read, m0_read};
  assign w_write    = {m1_write, m0_write};
  assign w_req      = w_read | w_write;
  assign w_addr[0]  = m0_address;
  assign w_addr[1]  = m1_address;
  assign w_be[0]    = m0_byteenable;
  assign w_be[1]    = m1_byteenable;
  assign w_wdata[0] = m0_writedata;
  assign w_wdata[1] = m1_writedata;

  assign w_issue   = (r_state == ISSUE);
  assign w_rd_done = (r_state == WAIT_RD) && (r_cnt == CNT_W'(1));

  rr_pick2 u_pick (
    .req     (w_req),
    .rr_last (r_rr_last),
    .winner  (w_winner),
    .valid   (w_pick_valid)
  );

  // Waitrequest is low only for the granted master during its single ISSUE cycle.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_wait
      assign w_wait[gi] = ~(w_issue && (r_grant == master_idx_t'(gi)));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_next = ISSUE;
          w_load       = 1'b1;
        end
      end
      ISSUE:   w_state_next = r_is_write ? IDLE : WAIT_RD;
      WAIT_RD: if (w_rd_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_grant   <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_grant   <= w_winner;
        r_rr_last <= w_winner;
      end
    end
  end

  // A master asserting both read and write is treated as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
    end else if (w_load) begin
      r_is_write <= w_write[w_winner];
      r_addr     <= w_addr[w_winner];
      r_be       <= w_be[w_winner];
      r_wdata    <= w_wdata[w_winner];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_issue && !r_is_write) begin
      r_cnt <= CNT_W'(READ_LATENCY);
    end else if (r_state == WAIT_RD) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Read data is captured on the last WAIT_RD cycle and held until the next read
  // completes for the same master; the valid strobe follows one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MASTERS; i++) r_rdata[i] <= '0;
      r_rdv <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        r_rdv[i] <= w_rd_done && (r_grant == master_idx_t'(i));
        if (w_rd_done && (r_grant == master_idx_t'(i))) r_rdata[i] <= mem_readdata;
      end
    end
  end

  assign m0_waitrequest   = w_wait[0];
  assign m1_waitrequest   = w_wait[1];
  assign m0_readdata      = r_rdata[0];
  assign m1_readdata      = r_rdata[1];
  assign m0_readdatavalid = r_rdv[0];
  assign m1_readdatavalid = r_rdv[1];

  assign mem_chipselect = w_issue;
  assign mem_write      = w_issue && r_is_write;
  assign mem_address    = r_addr;
  assign mem_byteenable = r_be;
  assign mem_writedata  = r_wdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: per-cycle vector table against a 1-cycle SRAM model, plus a
// hand-written sequence on a READ_LATENCY=3 instance.
module tb_onchip_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- latency-1 instance ----------------
  logic [1:0]  m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .BE_W(4), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  logic [31:0] mem1 [4];
  logic [31:0] q1;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem1[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        q1 <= mem1[mem_address];
      end
    end
  end
  assign mem_readdata = q1;

  // ---------------- latency-3 instance ----------------
  logic [1:0]  d3_m0_address = '0, d3_m1_address = '0;
  logic [3:0]  d3_m0_byteenable = '0, d3_m1_byteenable = '0;
  logic        d3_m0_read = 1'b0, d3_m0_write = 1'b0, d3_m1_read = 1'b0, d3_m1_write = 1'b0;
  logic [31:0] d3_m0_writedata = '0, d3_m1_writedata = '0;
  logic        d3_m0_wait, d3_m1_wait, d3_m0_rdv, d3_m1_rdv;
  logic [31:0] d3_m0_rdata, d3_m1_rdata;
  logic [1:0]  d3_mem_addr;
  logic [3:0]  d3_mem_be;
  logic        d3_mem_cs, d3_mem_wr;
  logic [31:0] d3_mem_wd, d3_mem_rdata;

  onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .BE_W(4), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .m0_address(d3_m0_address), .m0_byteenable(d3_m0_byteenable), .m0_read(d3_m0_read),
    .m0_write(d3_m0_write), .m0_writedata(d3_m0_writedata), .m0_waitrequest(d3_m0_wait),
    .m0_readdata(d3_m0_rdata), .m0_readdatavalid(d3_m0_rdv),
    .m1_address(d3_m1_address), .m1_byteenable(d3_m1_byteenable), .m1_read(d3_m1_read),
    .m1_write(d3_m1_write), .m1_writedata(d3_m1_writedata), .m1_waitrequest(d3_m1_wait),
    .m1_readdata(d3_m1_rdata), .m1_readdatavalid(d3_m1_rdv),
    .mem_address(d3_mem_addr), .mem_byteenable(d3_mem_be),
    .mem_chipselect(d3_mem_cs), .mem_write(d3_mem_wr),
    .mem_writedata(d3_mem_wd), .mem_readdata(d3_mem_rdata)
  );

  logic [31:0] mem3 [4];
  logic [31:0] p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    if (d3_mem_cs && d3_mem_wr) begin
      for (int b = 0; b < 4; b++)
        if (d3_mem_be[b]) mem3[d3_mem_addr][8*b +: 8] <= d3_mem_wd[8*b +: 8];
    end
    if (d3_mem_cs && !d3_mem_wr) p3_0 <= mem3[d3_mem_addr];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign d3_mem_rdata = p3_2;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  c0;  logic [1:0] a0;  logic [3:0] be0;  logic [31:0] wd0;
    logic [1:0]  c1;  logic [1:0] a1;  logic [3:0] be1;  logic [31:0] wd1;
    logic [1:0]  ew;                       // {m1_waitrequest, m0_waitrequest}
    logic        ecs; logic ewr; logic [1:0] ea; logic [3:0] ebe; logic [31:0] ewd;
    logic [1:0]  erdv;                     // {m1_readdatavalid, m0_readdatavalid}
    logic [31:0] erd0; logic [31:0] erd1;
  } vec_t;

  function automatic vec_t mk(
    input logic rst,
    input logic [1:0] c0, input logic [1:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
    input logic [1:0] c1, input logic [1:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
    input logic [1:0] ew, input logic ecs, input logic ewr, input logic [1:0] ea,
    input logic [3:0] ebe, input logic [31:0] ewd,
    input logic [1:0] erdv, input logic [31:0] erd0, input logic [31:0] erd1);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.a0 = a0; v.be0 = be0; v.wd0 = wd0;
    v.c1 = c1; v.a1 = a1; v.be1 = be1; v.wd1 = wd1;
    v.ew = ew; v.ecs = ecs; v.ewr = ewr; v.ea = ea; v.ebe = ebe; v.ewd = ewd;
    v.erdv = erdv; v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

  localparam logic        H = 1'b1, L = 1'b0;
  localparam logic [1:0]  NO = 2'b00, WR = 2'b01, RD = 2'b10;   // {read, write}
  localparam logic [1:0]  A0 = 2'd0, A1 = 2'd1, A2 = 2'd2, A3 = 2'd3;
  localparam logic [3:0]  BF = 4'hF, B2 = 4'h2, B0 = 4'h0;
  localparam logic [1:0]  W11 = 2'b11, W10 = 2'b10, W01 = 2'b01;
  localparam logic [1:0]  V00 = 2'b00, V01 = 2'b01, V10 = 2'b10;
  localparam logic [31:0] Z = 32'h0, D_BEEF = 32'hDEADBEEF, D_ONE = 32'h11111111,
                          D_TWO = 32'h22222222, D_BASE = 32'h12345678,
                          D_PATCH = 32'h0000AB00, D_MERGE = 32'h1234AB78,
                          D_CAFE = 32'hCAFEF00D;

  vec_t tv[$];

  initial begin
    // write from reset, then read back
    tv.push_back(mk(H, NO,A0,B0,Z,      NO,A0,B0,Z, W11,L,L,A0,B0,Z,      V00,Z,Z));
    tv.push_back(mk(L, WR,A2,BF,D_BEEF, NO,A0,B0,Z, W11,L,L,A0,B0,Z,      V00,Z,Z));
    tv.push_back(mk(L, WR,A2,BF,D_BEEF, NO,A0,B0,Z, W10,H,H,A2,BF,D_BEEF, V00,Z,Z));
    tv.push_back(mk(L, RD,A2,BF,Z,      NO,A0,B0,Z, W11,L,L,A0,B0,Z,      V00,Z,Z));
    tv.push_back(mk(L, RD,A2,BF,Z,      NO,A0,B0,Z, W10,H,L,A2,BF,Z,      V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z,      NO,A0,B0,Z, W11,L,L,A0,B0,Z,      V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z,      NO,A0,B0,Z, W11,L,L,A0,B0,Z,      V01,D_BEEF,Z));
    // contention: simultaneous writes from reset, then continuous reads
    tv.push_back(mk(H, NO,A0,B0,Z,      NO,A0,B0,Z,     W11,L,L,A0,B0,Z,     V00,Z,Z));
    tv.push_back(mk(L, WR,A0,BF,D_ONE,  WR,A1,BF,D_TWO, W11,L,L,A0,B0,Z,     V00,Z,Z));
    tv.push_back(mk(L, WR,A0,BF,D_ONE,  WR,A1,BF,D_TWO, W10,H,H,A0,BF,D_ONE, V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z,      WR,A1,BF,D_TWO, W11,L,L,A0,B0,Z,     V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z,      WR,A1,BF,D_TWO, W01,H,H,A1,BF,D_TWO, V00,Z,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V00,Z,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W10,H,L,A1,BF,Z,     V00,Z,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V00,Z,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V01,D_TWO,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W01,H,L,A0,BF,Z,     V00,D_TWO,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V00,D_TWO,Z));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V10,D_TWO,D_ONE));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W10,H,L,A1,BF,Z,     V00,D_TWO,D_ONE));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V00,D_TWO,D_ONE));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W11,L,L,A0,B0,Z,     V01,D_TWO,D_ONE));
    tv.push_back(mk(L, RD,A1,BF,Z,      RD,A0,BF,Z,     W01,H,L,A0,BF,Z,     V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      NO,A0,B0,Z,     W11,L,L,A0,B0,Z,     V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      NO,A0,B0,Z,     W11,L,L,A0,B0,Z,     V10,D_TWO,D_ONE));
    // byte-enable merge; read issued with a partial byteenable to check forwarding
    tv.push_back(mk(L, WR,A3,BF,D_BASE, NO,A0,B0,Z,       W11,L,L,A0,B0,Z,       V00,D_TWO,D_ONE));
    tv.push_back(mk(L, WR,A3,BF,D_BASE, NO,A0,B0,Z,       W10,H,H,A3,BF,D_BASE,  V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      WR,A3,B2,D_PATCH, W11,L,L,A0,B0,Z,       V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      WR,A3,B2,D_PATCH, W01,H,H,A3,B2,D_PATCH, V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      RD,A3,B2,Z,       W11,L,L,A0,B0,Z,       V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      RD,A3,B2,Z,       W01,H,L,A3,B2,Z,       V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      NO,A0,B0,Z,       W11,L,L,A0,B0,Z,       V00,D_TWO,D_ONE));
    tv.push_back(mk(L, NO,A0,B0,Z,      NO,A0,B0,Z,       W11,L,L,A0,B0,Z,       V10,D_TWO,D_MERGE));
    // reset during WAIT_RD discards the read; a fresh read afterwards works
    tv.push_back(mk(L, NO,A0,B0,Z, RD,A1,BF,Z, W11,L,L,A0,B0,Z,  V00,D_TWO,D_MERGE));
    tv.push_back(mk(L, NO,A0,B0,Z, RD,A1,BF,Z, W01,H,L,A1,BF,Z,  V00,D_TWO,D_MERGE));
    tv.push_back(mk(H, NO,A0,B0,Z, NO,A0,B0,Z, W11,L,L,A0,B0,Z,  V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z, NO,A0,B0,Z, W11,L,L,A0,B0,Z,  V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z, NO,A0,B0,Z, W11,L,L,A0,B0,Z,  V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z, RD,A1,BF,Z, W11,L,L,A0,B0,Z,  V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z, RD,A1,BF,Z, W01,H,L,A1,BF,Z,  V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z, NO,A0,B0,Z, W11,L,L,A0,B0,Z,  V00,Z,Z));
    tv.push_back(mk(L, NO,A0,B0,Z, NO,A0,B0,Z, W11,L,L,A0,B0,Z,  V10,Z,D_TWO));
    tv.push_back(mk(L, NO,A0,B0,Z, NO,A0,B0,Z, W11,L,L,A0,B0,Z,  V00,Z,D_TWO));

    // reset state of both instances
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hs", 64'({m1_waitrequest, m0_waitrequest, m1_readdatavalid, m0_readdatavalid}), 64'(4'b1100));
    chk("rst_bus", 64'({mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata}), 64'(0));
    chk("rst_rdata", {m1_readdata, m0_readdata}, 64'(0));
    chk("rst3_hs", 64'({d3_m1_wait, d3_m0_wait, d3_m1_rdv, d3_m0_rdv}), 64'(4'b1100));
    chk("rst3_bus", 64'({d3_mem_cs, d3_mem_wr, d3_mem_addr, d3_mem_be, d3_mem_wd}), 64'(0));

    foreach (tv[k]) begin
      @(negedge clk);
      reset_n = ~tv[k].rst;
      {m0_read, m0_write} = tv[k].c0;
      m0_address = tv[k].a0; m0_byteenable = tv[k].be0; m0_writedata = tv[k].wd0;
      {m1_read, m1_write} = tv[k].c1;
      m1_address = tv[k].a1; m1_byteenable = tv[k].be1; m1_writedata = tv[k].wd1;
      #1;
      chk($sformatf("v%0d_hs", k),
          64'({m1_waitrequest, m0_waitrequest, m1_readdatavalid, m0_readdatavalid}),
          64'({tv[k].ew, tv[k].erdv}));
      if (tv[k].ecs)
        chk($sformatf("v%0d_bus", k),
            64'({mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata}),
            64'({tv[k].ecs, tv[k].ewr, tv[k].ea, tv[k].ebe, tv[k].ewd}));
      else
        chk($sformatf("v%0d_cs", k), 64'({mem_chipselect, mem_write}), 64'({tv[k].ecs, tv[k].ewr}));
      chk($sformatf("v%0d_rdata", k), {m1_readdata, m0_readdata}, {tv[k].erd1, tv[k].erd0});
      $display("row %0d: rst=%b wait=%b%b cs=%b wr=%b addr=%0d rdv=%b%b rd0=%h rd1=%h",
               k, tv[k].rst, m1_waitrequest, m0_waitrequest, mem_chipselect, mem_write,
               mem_address, m1_readdatavalid, m0_readdatavalid, m0_readdata, m1_readdata);
    end

    // READ_LATENCY=3: write addr2, then read it back; valid expected at T5 only
    @(negedge clk);
    d3_m0_write = 1'b1; d3_m0_address = A2; d3_m0_byteenable = BF; d3_m0_writedata = D_CAFE;
    #1 chk("l3_wr_idle_wait", 64'(d3_m0_wait), 64'(1));
    @(negedge clk);
    #1 chk("l3_wr_issue", 64'({d3_m0_wait, d3_mem_cs, d3_mem_wr, d3_mem_addr, d3_mem_wd}),
           64'({L, H, H, A2, D_CAFE}));
    d3_m0_write = 1'b0;
    $display("l3 write: addr=%0d data=%h", d3_mem_addr, d3_mem_wd);
    @(negedge clk);
    d3_m0_read = 1'b1; d3_m0_writedata = Z;
    #1 chk("l3_rd_t0_wait", 64'(d3_m0_wait), 64'(1));
    @(negedge clk);
    #1 chk("l3_rd_t1_issue", 64'({d3_m0_wait, d3_mem_cs, d3_mem_wr, d3_mem_addr}), 64'({L, H, L, A2}));
    d3_m0_read = 1'b0;
    for (int t = 2; t <= 6; t++) begin
      @(negedge clk);
      #1;
      chk($sformatf("l3_rdv_t%0d", t), 64'({d3_m1_rdv, d3_m0_rdv}), 64'((t == 5) ? 2'b01 : 2'b00));
      if (t == 5) chk("l3_rdata", 64'(d3_m0_rdata), 64'(D_CAFE));
      $display("l3 read t%0d: rdv=%b%b rd0=%h", t, d3_m1_rdv, d3_m0_rdv, d3_m0_rdata);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
